// File: rtl/mem_burst_reader.sv
// mem_burst_reader: streams a burst of consecutive simple_mem reads onto a valid/ready output.
// Reads are only issued when the FIFO has room for every word still in flight, so stalls never drop data.
module mem_burst_reader #(
  parameter int RD_LATENCY = 1,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);
  localparam int DEPTH = RD_LATENCY + 2;
  localparam int PW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] next_addr;
  logic [ADDR_W:0] issue_rem;
  logic [RD_LATENCY:0] pv, pl;
  logic [DATA_W-1:0] fifo_d [DEPTH];
  logic [DEPTH-1:0] fifo_l;
  logic [PW-1:0] wp, rp;
  logic [7:0] count, inflight;
  logic push, pop, issue, last_issue;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    inflight = '0;
    for (int i = 0; i <= RD_LATENCY; i++) inflight = inflight + 8'(pv[i]);
  end

  assign out_valid = count != '0;
  assign out_data = out_valid ? fifo_d[rp] : '0;
  assign out_last = out_valid && fifo_l[rp];
  assign pop = out_valid && out_ready;
  assign push = pv[RD_LATENCY];
  // Words in the FIFO plus reads still in the memory pipe must fit after this cycle's pop
  assign issue = state == RUN && issue_rem != '0 && count + inflight < 8'(DEPTH) + 8'(pop);
  assign last_issue = issue && issue_rem == {{ADDR_W{1'b0}}, 1'b1};

  always_ff @(posedge clk) state <= !rst_n ? IDLE : state_nx;

  always_comb begin
    state_nx = state;
    busy = state != IDLE;
    done = state == FIN;
    unique case (state)
      IDLE:    if (start) state_nx = length == '0 ? FIN : RUN;
      RUN:     if (last_issue) state_nx = DRAIN;
      DRAIN:   if (pop && out_last) state_nx = FIN;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      address <= '0;
      next_addr <= '0;
      issue_rem <= '0;
      pv <= '0;
      pl <= '0;
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (state == IDLE && start) begin
        next_addr <= base_addr;
        issue_rem <= length;
      end
      if (issue) begin
        address <= next_addr;
        next_addr <= next_addr + 1'b1;
        issue_rem <= issue_rem - 1'b1;
      end
      pv[0] <= issue;
      pl[0] <= last_issue;
      for (int i = 1; i <= RD_LATENCY; i++) begin
        pv[i] <= pv[i-1];
        pl[i] <= pl[i-1];
      end
      if (push) wp <= nxt(wp);
      if (pop) rp <= nxt(rp);
      count <= count + 8'(push) - 8'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_d[wp] <= mem_data;
      fifo_l[wp] <= pl[RD_LATENCY];
    end
  end
endmodule

// File: doc/mem_burst_reader.md
Name: mem_burst_reader

Overview:
Upstream address sequencer and downstream data collector for the simple_mem block. It drives simple_mem's 8-bit address to stream a burst of consecutive locations. It captures the returned 18-bit mem_data after a fixed read latency and presents the words on a valid/ready output stream. Credit-based flow control means no word is ever dropped when the consumer stalls.

Parameters:
RD_LATENCY, 1, clock edges after an address update until mem_data for that address is valid; 0 = combinational memory.
ADDR_W, 8, memory address width; must match simple_mem.
DATA_W, 18, memory data width; must match simple_mem.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
start  input  1  burst request; sampled only when idle
base_addr  input  ADDR_W  first address of the burst, captured with start
length  input  ADDR_W+1  number of words to read, 0..256
address  output  ADDR_W  registered address to simple_mem
mem_data  input  DATA_W  read data from simple_mem
out_data  output  DATA_W  head-of-FIFO read word
out_valid  output  1  out_data is valid
out_ready  input  1  consumer accepts the word when out_valid && out_ready
out_last  output  1  qualifies out_data as the final word of the burst
busy  output  1  burst in progress
done  output  1  one-cycle pulse at burst completion

Behaviour:
- Reset (rst_n low at an edge): address=0, out_data=0, out_valid=0, out_last=0, busy=0, done=0, state=IDLE. FIFO is emptied, the in-flight pipeline is cleared, and remaining count is cleared.
- Reset mid-burst: all in-flight reads are discarded. No done pulse is generated for the aborted burst.
- States:
  - IDLE: on start=1, capture base_addr and length.
  - length=0: go to FIN.
  - length>0: go to RUN.
  - start is ignored in all states except IDLE.
- RUN issue rule: issue a read when remaining issues > 0 and fifo_count + inflight - pop < DEPTH, where DEPTH = RD_LATENCY+2 and pop = out_valid && out_ready.
- On issue: address <= next address, next address increments modulo 2^ADDR_W (0xFF wraps to 0x00), remaining issues decrements. The first issue drives base_addr.
- Read capture: a read issued at edge E writes mem_data into the FIFO at edge E+RD_LATENCY+1. Track this with a valid shift pipeline of depth RD_LATENCY+1.
- Transition RUN -> DRAIN when the last issue is made.
- Transition DRAIN -> FIN on the edge where the last word is popped.
- FIN: done=1 for exactly one cycle, then IDLE.
- busy is 1 in RUN, DRAIN and FIN; 0 in IDLE.
- A length=0 burst gives busy=1 and done=1 in the single FIN cycle, then returns to IDLE.
- address holds its last issued value whenever no issue occurs, including in IDLE.
- Output stream:
  - out_valid = FIFO not empty; out_data and out_last come from the FIFO head.
  - out_data is stable while out_valid && !out_ready.
  - out_last is set on the word whose index is length-1.
- Simultaneous FIFO push and pop in the same cycle are both honoured; fifo_count is unchanged.
- FIFO can never overflow given the credit rule; the verifier asserts fifo_count <= DEPTH.
- Throughput: with out_ready held at 1, the block issues one address per cycle. The first word appears RD_LATENCY+2 cycles after start is sampled.
- Full burst: length=256 wraps base_addr through all addresses exactly once.

Test Plan:
- Bench memory model mem[a] = {10'h2A5, a}, RD_LATENCY=1, out_ready=1, start with base_addr=0x10, length=4 -> address 0x10..0x13 on consecutive cycles; out_data 0x2A510..0x2A513 on 4 consecutive cycles; out_last on the 4th; done 1 cycle after; busy drops with IDLE.
- Wrap: base_addr=0xFE, length=4 -> addresses FE, FF, 00, 01; data order matches; no gaps.
- Backpressure: length=8, out_ready low for cycles 3..10 after start -> issue stalls with fifo_count + inflight <= 3; no word lost or duplicated; all 8 words delivered in order once out_ready returns high.
- length=0 -> no address change; done pulses once with no out_valid; start during busy of a length=5 burst -> ignored, exactly 5 words out.
- Reset asserted 2 cycles into a length=6 burst -> next edge gives all outputs at reset values and no done; a fresh length=2 burst afterwards completes normally.
- RD_LATENCY=0 and RD_LATENCY=3 builds with the same length=6 random-ready stimulus -> identical in-order output sequences; the first-word timing follows RD_LATENCY+2.
